fetch_instr_queue: RTL and testbench

FETCH_INSTR_QUEUE -- requirements
Module: fetch_instr_queue

---
 rtl/config_pkg.sv | 30 +++
 rtl/fetch_slot_compact.sv | 43 ++++
 rtl/fetch_instr_queue.sv | 100 ++++++++++
 tb/tb_fetch_instr_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared frontend configuration: widths, control-flow and exception types,
// and the entry format handed from fetch to the backend.
package config_pkg;

  localparam int XLEN        = 32;
  localparam int VLEN        = 32;
  localparam int FETCH_WIDTH = 2;

  typedef enum logic [2:0] {
    NO_CF,
    BRANCH,
    JUMP,
    JUMP_R,
    RETURN
  } cf_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } frontend_exception_t;

  typedef struct packed {
    logic [XLEN-1:0]     instr;
    logic [VLEN-1:0]     ex_vaddr;
    cf_t                 cf;
    logic [VLEN-1:0]     predict_address;
    frontend_exception_t ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_compact.sv
// Per-cycle slot acceptance: prefix count of valid slots gives each slot
// its write offset; slots are taken in order until the free space runs out.
module fetch_slot_compact #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned CW          = 4,
  parameter int unsigned PW          = 3
) (
  input  logic [FETCH_WIDTH-1:0]         valid_i,
  input  logic [CW-1:0]                  free_i,
  output logic [FETCH_WIDTH-1:0]         accept_o,
  output logic [FETCH_WIDTH-1:0]         reject_sel_o,
  output logic [FETCH_WIDTH-1:0][PW-1:0] widx_o,
  output logic [CW-1:0]                  n_accept_o
);

  logic [CW-1:0] seen;
  logic [CW-1:0] n_acc;
  logic          hit;

  always_comb begin
    seen         = '0;
    n_acc        = '0;
    hit          = 1'b0;
    accept_o     = '0;
    reject_sel_o = '0;
    widx_o       = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      widx_o[i] = seen[PW-1:0];
      if (valid_i[i]) begin
        if (seen < free_i) begin
          accept_o[i] = 1'b1;
          n_acc       = n_acc + CW'(1);
        end else if (!hit) begin
          reject_sel_o[i] = 1'b1;
          hit             = 1'b1;
        end
        seen = seen + CW'(1);
      end
    end
    n_accept_o = n_acc;
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// Fetch-to-backend instruction queue: multi-slot in-order push,
// single-entry pop, replay of the oldest slot that did not fit.
module fetch_instr_queue
  import config_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = config_pkg::FETCH_WIDTH,
  parameter int unsigned DEPTH       = 8,
  parameter type fetch_entry_t       = config_pkg::fetch_entry_t
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic [FETCH_WIDTH-1:0]                      valid_i,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]            instr_i,
  input  logic [FETCH_WIDTH-1:0][VLEN-1:0]            addr_i,
  input  cf_t [FETCH_WIDTH-1:0]                       cf_type_i,
  input  logic [FETCH_WIDTH-1:0][VLEN-1:0]            predict_address_i,
  input  frontend_exception_t [FETCH_WIDTH-1:0]       exception_i,
  output logic                                        ready_o,
  output logic [FETCH_WIDTH-1:0]                      consumed_o,
  output logic                                        replay_o,
  output logic [VLEN-1:0]                             replay_addr_o,
  output fetch_entry_t                                fetch_entry_o,
  output logic                                        fetch_entry_valid_o,
  input  logic                                        fetch_entry_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]                  count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t                          mem_q [DEPTH];
  fetch_entry_t                          wr_ent [FETCH_WIDTH];
  logic [PW-1:0]                         rptr_q, wptr_q;
  logic [CW-1:0]                         count_q, free, n_acc, n_push;
  logic [FETCH_WIDTH-1:0]                acc, rsel;
  logic [FETCH_WIDTH-1:0][PW-1:0]        widx;
  logic                                  en, empty, pop;
  logic [VLEN-1:0]                       raddr;

  assign en     = rst_ni & ~flush_i;
  assign empty  = (count_q == '0);
  assign free   = CW'(DEPTH) - count_q;
  assign n_push = en ? n_acc : '0;
  assign pop    = en & ~empty & fetch_entry_ready_i;

  fetch_slot_compact #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .CW          (CW),
    .PW          (PW)
  ) u_compact (
    .valid_i      (valid_i),
    .free_i       (free),
    .accept_o     (acc),
    .reject_sel_o (rsel),
    .widx_o       (widx),
    .n_accept_o   (n_acc)
  );

  always_comb begin
    raddr = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      wr_ent[i]                 = '0;
      wr_ent[i].instr           = instr_i[i];
      wr_ent[i].ex_vaddr        = addr_i[i];
      wr_ent[i].cf              = cf_type_i[i];
      wr_ent[i].predict_address = predict_address_i[i];
      wr_ent[i].ex              = exception_i[i];
      if (rsel[i]) raddr = raddr | addr_i[i];
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign ready_o             = ~rst_ni | (free >= CW'(FETCH_WIDTH));
  assign consumed_o          = en ? acc : '0;
  assign replay_o            = en & (|rsel);
  assign replay_addr_o       = en ? raddr : '0;
  assign fetch_entry_valid_o = rst_ni & ~empty;
  assign fetch_entry_o       = fetch_entry_valid_o ? mem_q[rptr_q] : '0;
  assign count_o             = rst_ni ? count_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) rptr_q <= rptr_q + PW'(1);
      wptr_q  <= wptr_q + PW'(n_push);
      count_q <= count_q + n_push - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      if (en && acc[i]) mem_q[wptr_q + widx[i]] <= wr_ent[i];
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_fetch_instr_queue;
  import config_pkg::*;

  localparam int DEPTH = 8;

  logic                       clk = 1'b0;
  logic                       rst_ni;
  logic                       flush_i;
  logic [1:0]                 valid_i;
  logic [1:0][XLEN-1:0]       instr_i;
  logic [1:0][VLEN-1:0]       addr_i;
  cf_t [1:0]                  cf_type_i;
  logic [1:0][VLEN-1:0]       predict_address_i;
  frontend_exception_t [1:0]  exception_i;
  logic                       ready_o;
  logic [1:0]                 consumed_o;
  logic                       replay_o;
  logic [VLEN-1:0]            replay_addr_o;
  fetch_entry_t               fetch_entry_o;
  logic                       fetch_entry_valid_o;
  logic                       fetch_entry_ready_i;
  logic [3:0]                 count_o;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  fetch_instr_queue #(
    .FETCH_WIDTH (2),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .instr_i             (instr_i),
    .addr_i              (addr_i),
    .cf_type_i           (cf_type_i),
    .predict_address_i   (predict_address_i),
    .exception_i         (exception_i),
    .ready_o             (ready_o),
    .consumed_o          (consumed_o),
    .replay_o            (replay_o),
    .replay_addr_o       (replay_addr_o),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (fetch_entry_ready_i),
    .count_o             (count_o)
  );

  typedef struct {
    bit          rst;
    bit          fl;
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] a1;
    bit          rdy;
    logic [1:0]  cons;
    bit          rep;
    logic [31:0] raddr;
    bit          rdyo;
    bit          hv;
    logic [31:0] head;
    logic [3:0]  cnt;
  } vec_t;

  function automatic fetch_entry_t mk(logic [31:0] a);
    fetch_entry_t e;
    e.instr           = ~a;
    e.ex_vaddr        = a;
    e.cf              = cf_t'({2'b00, a[2]});
    e.predict_address = a + 32'h40;
    e.ex.valid        = a[3];
    e.ex.cause        = a[7:4];
    return e;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, bit fl, logic [1:0] v,
                       logic [31:0] a0, logic [31:0] a1, bit rdy);
    fetch_entry_t e0, e1;
    e0 = mk(a0);
    e1 = mk(a1);
    rst_ni               = rst;
    flush_i              = fl;
    valid_i              = v;
    fetch_entry_ready_i  = rdy;
    addr_i[0]            = a0;
    addr_i[1]            = a1;
    instr_i[0]           = e0.instr;
    instr_i[1]           = e1.instr;
    cf_type_i[0]         = e0.cf;
    cf_type_i[1]         = e1.cf;
    predict_address_i[0] = e0.predict_address;
    predict_address_i[1] = e1.predict_address;
    exception_i[0]       = e0.ex;
    exception_i[1]       = e1.ex;
  endtask

  task automatic cyc(bit rst, bit fl, logic [1:0] v,
                     logic [31:0] a0, logic [31:0] a1, bit rdy);
    logic [31:0]  a [2];
    logic [1:0]   ec;
    bit           er, hv;
    logic [31:0]  ea;
    int           free, n;
    fetch_entry_t eh;
    a[0] = a0;
    a[1] = a1;
    drive(rst, fl, v, a0, a1, rdy);
    #1;
    ec   = '0;
    er   = 1'b0;
    ea   = '0;
    n    = 0;
    free = DEPTH - q.size();
    if (rst && !fl) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (n < free) ec[i] = 1'b1;
          else if (!er) begin
            er = 1'b1;
            ea = a[i];
          end
          n++;
        end
      end
    end
    hv = rst && (q.size() > 0);
    eh = hv ? mk(q[0]) : '0;
    chk("consumed", consumed_o, ec);
    chk("replay", replay_o, er);
    chk("replay_addr", replay_addr_o, ea);
    chk("ready", ready_o, (!rst || free >= 2));
    chk("head_valid", fetch_entry_valid_o, hv);
    chk("head_entry", fetch_entry_o, eh);
    @(posedge clk);
    if (!rst || fl) q.delete();
    else begin
      if (hv && rdy) void'(q.pop_front());
      for (int i = 0; i < 2; i++) if (ec[i]) q.push_back(a[i]);
    end
    #1;
    chk("count", count_o, q.size());
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    drive(1'b0, 1'b0, 2'b11, 32'h10, 32'h14, 1'b1);
    cyc(1'b0, 1'b0, 2'b11, 32'h10, 32'h14, 1'b1);
    cyc(1'b0, 1'b0, 2'b11, 32'h10, 32'h14, 1'b1);

    //          rst fl  v      a0        a1        rdy cons  rep raddr     rdyo hv  head      cnt
    tbl.push_back('{1, 0, 2'b11, 32'h100, 32'h104, 0, 2'b11, 0, 32'h0,   1, 0, 32'h0,   4'd2});
    tbl.push_back('{1, 0, 2'b00, 32'h0,   32'h0,   1, 2'b00, 0, 32'h0,   1, 1, 32'h100, 4'd1});
    tbl.push_back('{1, 0, 2'b10, 32'hdea0, 32'h204, 0, 2'b10, 0, 32'h0,  1, 1, 32'h104, 4'd2});
    tbl.push_back('{1, 0, 2'b11, 32'h210, 32'h214, 0, 2'b11, 0, 32'h0,   1, 1, 32'h104, 4'd4});
    tbl.push_back('{1, 0, 2'b11, 32'h220, 32'h224, 0, 2'b11, 0, 32'h0,   1, 1, 32'h104, 4'd6});
    tbl.push_back('{1, 0, 2'b01, 32'h230, 32'h234, 0, 2'b01, 0, 32'h0,   1, 1, 32'h104, 4'd7});
    tbl.push_back('{1, 0, 2'b11, 32'h300, 32'h304, 1, 2'b01, 1, 32'h304, 0, 1, 32'h104, 4'd7});
    tbl.push_back('{1, 1, 2'b11, 32'h310, 32'h314, 1, 2'b00, 0, 32'h0,   0, 1, 32'h204, 4'd0});
    tbl.push_back('{1, 0, 2'b11, 32'h400, 32'h404, 0, 2'b11, 0, 32'h0,   1, 0, 32'h0,   4'd2});
    tbl.push_back('{0, 0, 2'b11, 32'h410, 32'h414, 1, 2'b00, 0, 32'h0,   1, 0, 32'h0,   4'd0});
    tbl.push_back('{1, 0, 2'b00, 32'h0,   32'h0,   0, 2'b00, 0, 32'h0,   1, 0, 32'h0,   4'd0});

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].fl, tbl[k].v, tbl[k].a0, tbl[k].a1, tbl[k].rdy);
      #1;
      chk($sformatf("t%0d_consumed", k), consumed_o, tbl[k].cons);
      chk($sformatf("t%0d_replay", k), replay_o, tbl[k].rep);
      chk($sformatf("t%0d_replay_addr", k), replay_addr_o, tbl[k].raddr);
      chk($sformatf("t%0d_ready", k), ready_o, tbl[k].rdyo);
      chk($sformatf("t%0d_head_valid", k), fetch_entry_valid_o, tbl[k].hv);
      chk($sformatf("t%0d_head", k), fetch_entry_o,
          tbl[k].hv ? mk(tbl[k].head) : '0);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_count", k), count_o, tbl[k].cnt);
      @(negedge clk);
    end
    q.delete();

    // Full queue held, then drained across the pointer wrap.
    cyc(1'b1, 1'b0, 2'b11, 32'h500, 32'h504, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 1'b0, 2'b11, 32'h600 + 16 * k, 32'h608 + 16 * k, 1'b0);
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 1'b0, 2'b11, 32'h700 + 16 * k, 32'h708 + 16 * k, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    // Flush and reset with five entries held.
    for (int r = 0; r < 2; r++) begin
      cyc(1'b1, 1'b0, 2'b11, 32'h800, 32'h804, 1'b0);
      cyc(1'b1, 1'b0, 2'b11, 32'h810, 32'h814, 1'b0);
      cyc(1'b1, 1'b0, 2'b01, 32'h820, 32'h824, 1'b0);
      cyc(r == 1 ? 1'b0 : 1'b1, r == 0 ? 1'b1 : 1'b0,
          2'b11, 32'h830, 32'h834, 1'b1);
      cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    end

    for (int k = 0; k < 600; k++) begin
      bit rst, fl, rdy;
      rst = ($urandom % 100) != 0;
      fl  = ($urandom % 30) == 0;
      rdy = (k < 300) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
      cyc(rst, fl, 2'($urandom), $urandom & 32'hffff_fffc,
          $urandom & 32'hffff_fffc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
